// File: rtl/alu_arbiter_if.sv
// Request/response handshake bundle between two clients and the ALU arbiter.
// Clients drive through master, the arbiter drives through slave.
interface alu_arbiter_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned SW = 3,
  parameter int unsigned OW = 8
);
  logic          req0_valid;
  logic          req0_ready;
  logic [AW-1:0] req0_a;
  logic [AW-1:0] req0_b;
  logic [SW-1:0] req0_s;
  logic          req1_valid;
  logic          req1_ready;
  logic [AW-1:0] req1_a;
  logic [AW-1:0] req1_b;
  logic [SW-1:0] req1_s;
  logic          rsp0_valid;
  logic          rsp0_ready;
  logic [OW-1:0] rsp0_o;
  logic          rsp1_valid;
  logic          rsp1_ready;
  logic [OW-1:0] rsp1_o;

  modport master (
    output req0_valid, req0_a, req0_b, req0_s, rsp0_ready,
    output req1_valid, req1_a, req1_b, req1_s, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_o,
    input  req1_ready, rsp1_valid, rsp1_o
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_s, rsp0_ready,
    input  req1_valid, req1_a, req1_b, req1_s, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_o,
    output req1_ready, rsp1_valid, rsp1_o
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one registered ALU between two requesters: accept one
// operation, hold operands for the ALU latency, then return the captured result.
module alu_arbiter #(
  parameter int unsigned AW      = 4,
  parameter int unsigned SW      = 3,
  parameter int unsigned OW      = 8,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic          clock,
  input  logic          reset_n,
  alu_arbiter_if.slave  bus,
  output logic [AW-1:0] alu_a,
  output logic [AW-1:0] alu_b,
  output logic [SW-1:0] alu_s,
  input  logic [OW-1:0] alu_o,
  output logic          busy,
  output logic          grant_id
);

  localparam int unsigned CW = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_grant;
  logic          rsp0_valid_q;
  logic          rsp1_valid_q;
  logic [OW-1:0] rsp0_o_q;
  logic [OW-1:0] rsp1_o_q;
  logic          winner_c;
  logic          accept_c;
  logic          rsp_done_c;

  // A lone request wins outright; a tie goes to whoever was not served last.
  always_comb begin
    winner_c = ~last_grant;
    if (bus.req0_valid && !bus.req1_valid) begin
      winner_c = 1'b0;
    end else if (bus.req1_valid && !bus.req0_valid) begin
      winner_c = 1'b1;
    end
  end

  assign accept_c   = (state == IDLE) && (winner_c ? bus.req1_valid : bus.req0_valid);
  assign rsp_done_c = grant_id ? bus.rsp1_ready : bus.rsp0_ready;

  assign bus.req0_ready = (state == IDLE) && !winner_c;
  assign bus.req1_ready = (state == IDLE) &&  winner_c;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp0_o     = rsp0_o_q;
  assign bus.rsp1_o     = rsp1_o_q;

  // EXEC spans ALU_LAT+1 edges: counter loads ALU_LAT and capture happens at zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      last_grant   <= 1'b1;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_s        <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_o_q     <= '0;
      rsp1_o_q     <= '0;
      busy         <= 1'b0;
      grant_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            alu_a    <= winner_c ? bus.req1_a : bus.req0_a;
            alu_b    <= winner_c ? bus.req1_b : bus.req0_b;
            alu_s    <= winner_c ? bus.req1_s : bus.req0_s;
            grant_id <= winner_c;
            cnt      <= CW'(ALU_LAT);
            busy     <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            if (grant_id) begin
              rsp1_o_q     <= alu_o;
              rsp1_valid_q <= 1'b1;
            end else begin
              rsp0_o_q     <= alu_o;
              rsp0_valid_q <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (rsp_done_c) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            last_grant   <= grant_id;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with ALU_LAT=1 and one with
// ALU_LAT=3, each wired to a behavioural registered ALU of matching depth.
module tb_alu_arbiter;

  logic       clock;
  logic       reset_n;
  logic [3:0] la_a, la_b, lb_a, lb_b;
  logic [2:0] la_s, lb_s;
  logic [7:0] la_o, lb_o, lb_p1, lb_p2;
  logic       la_busy, la_gid, lb_busy, lb_gid;
  int         n_vec = 0;
  int         n_err = 0;

  alu_arbiter_if #(.AW(4), .SW(3), .OW(8)) ifa ();
  alu_arbiter_if #(.AW(4), .SW(3), .OW(8)) ifb ();

  alu_arbiter #(.AW(4), .SW(3), .OW(8), .ALU_LAT(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(ifa.slave),
    .alu_a(la_a), .alu_b(la_b), .alu_s(la_s), .alu_o(la_o),
    .busy(la_busy), .grant_id(la_gid)
  );

  alu_arbiter #(.AW(4), .SW(3), .OW(8), .ALU_LAT(3)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(ifb.slave),
    .alu_a(lb_a), .alu_b(lb_b), .alu_s(lb_s), .alu_o(lb_o),
    .busy(lb_busy), .grant_id(lb_gid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] s);
    case (s)
      3'b000:  return 8'(a) + 8'(b);
      3'b001:  return 8'(a) * 8'(b);
      3'b011:  return (a != b) ? 8'h01 : 8'h00;
      3'b100:  return 8'(a & b);
      3'b101:  return 8'(a | b);
      3'b110:  return 8'(a ^ b);
      default: return ~(8'(a));
    endcase
  endfunction

  // Registered ALU models: one stage for dut_a, three stages for dut_b.
  always_ff @(posedge clock) la_o <= alu_f(la_a, la_b, la_s);
  always_ff @(posedge clock) begin
    lb_p1 <= alu_f(lb_a, lb_b, lb_s);
    lb_p2 <= lb_p1;
    lb_o  <= lb_p2;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One full operation on dut_a with rsp_ready held high by the caller.
  task automatic run_op(input string tag, input logic p, input logic [3:0] a,
                        input logic [3:0] b, input logic [2:0] s, input logic [7:0] exp);
    if (p) begin
      ifa.req1_valid = 1'b1; ifa.req1_a = a; ifa.req1_b = b; ifa.req1_s = s;
    end else begin
      ifa.req0_valid = 1'b1; ifa.req0_a = a; ifa.req0_b = b; ifa.req0_s = s;
    end
    #1;
    chk({tag, "_ready"}, 16'(p ? ifa.req1_ready : ifa.req0_ready), 16'h1);
    step();
    ifa.req0_valid = 1'b0;
    ifa.req1_valid = 1'b0;
    chk({tag, "_gid"}, 16'(la_gid), 16'(p));
    chk({tag, "_alu_s"}, 16'(la_s), 16'(s));
    step();
    step();
    chk({tag, "_rsp_valid"}, 16'(p ? ifa.rsp1_valid : ifa.rsp0_valid), 16'h1);
    chk({tag, "_rsp_o"}, 16'(p ? ifa.rsp1_o : ifa.rsp0_o), 16'(exp));
    step();
    chk({tag, "_busy_end"}, 16'(la_busy), 16'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic g;
    reset_n = 1'b0;
    ifa.req0_valid = 1'b0; ifa.req0_a = '0; ifa.req0_b = '0; ifa.req0_s = '0;
    ifa.req1_valid = 1'b0; ifa.req1_a = '0; ifa.req1_b = '0; ifa.req1_s = '0;
    ifa.rsp0_ready = 1'b0; ifa.rsp1_ready = 1'b0;
    ifb.req0_valid = 1'b0; ifb.req0_a = '0; ifb.req0_b = '0; ifb.req0_s = '0;
    ifb.req1_valid = 1'b0; ifb.req1_a = '0; ifb.req1_b = '0; ifb.req1_s = '0;
    ifb.rsp0_ready = 1'b1; ifb.rsp1_ready = 1'b1;
    step();
    step();

    // Reset values
    chk("rst_busy", 16'(la_busy), 16'h0);
    chk("rst_gid", 16'(la_gid), 16'h0);
    chk("rst_alu_a", 16'(la_a), 16'h0);
    chk("rst_alu_s", 16'(la_s), 16'h0);
    chk("rst_rsp0_valid", 16'(ifa.rsp0_valid), 16'h0);
    chk("rst_rsp1_o", 16'(ifa.rsp1_o), 16'h0);
    chk("rst_req0_ready", 16'(ifa.req0_ready), 16'h1);
    chk("rst_req1_ready", 16'(ifa.req1_ready), 16'h0);
    reset_n = 1'b1;
    ifa.rsp0_ready = 1'b1;
    ifa.rsp1_ready = 1'b1;
    step();

    // Single add with detailed latency checks
    ifa.req0_valid = 1'b1; ifa.req0_a = 4'h7; ifa.req0_b = 4'h9; ifa.req0_s = 3'b000;
    #1;
    chk("add_req0_ready", 16'(ifa.req0_ready), 16'h1);
    step();
    ifa.req0_valid = 1'b0;
    chk("add_busy_exec", 16'(la_busy), 16'h1);
    chk("add_alu_a", 16'(la_a), 16'h7);
    chk("add_alu_b", 16'(la_b), 16'h9);
    chk("add_req0_ready_exec", 16'(ifa.req0_ready), 16'h0);
    step();
    chk("add_rsp0_early", 16'(ifa.rsp0_valid), 16'h0);
    step();
    chk("add_rsp0_valid", 16'(ifa.rsp0_valid), 16'h1);
    chk("add_rsp0_o", 16'(ifa.rsp0_o), 16'h10);
    chk("add_busy_resp", 16'(la_busy), 16'h1);
    step();
    chk("add_rsp0_clear", 16'(ifa.rsp0_valid), 16'h0);
    chk("add_busy_idle", 16'(la_busy), 16'h0);

    // Fresh reset so the tie goes to req0
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();

    // Tie then fairness: both held valid, grants alternate 0,1,0,1
    ifa.req0_valid = 1'b1; ifa.req0_a = 4'h3; ifa.req0_b = 4'h4; ifa.req0_s = 3'b000;
    ifa.req1_valid = 1'b1; ifa.req1_a = 4'hA; ifa.req1_b = 4'h5; ifa.req1_s = 3'b110;
    #1;
    chk("tie_req0_ready", 16'(ifa.req0_ready), 16'h1);
    chk("tie_req1_ready", 16'(ifa.req1_ready), 16'h0);
    for (int k = 0; k < 4; k++) begin
      g = k[0];
      step();
      chk("tie_gid", 16'(la_gid), 16'(g));
      chk("tie_alu_a", 16'(la_a), g ? 16'hA : 16'h3);
      step();
      step();
      chk("tie_rsp_valid", 16'(g ? ifa.rsp1_valid : ifa.rsp0_valid), 16'h1);
      chk("tie_other_valid", 16'(g ? ifa.rsp0_valid : ifa.rsp1_valid), 16'h0);
      chk("tie_rsp_o", 16'(g ? ifa.rsp1_o : ifa.rsp0_o), g ? 16'h0F : 16'h07);
      step();
      chk("tie_next_ready", 16'(g ? ifa.req0_ready : ifa.req1_ready), 16'h1);
    end
    ifa.req0_valid = 1'b0;
    ifa.req1_valid = 1'b0;

    // Multiply, not, neq and the remaining opcodes
    run_op("mul", 1'b1, 4'hF, 4'hF, 3'b001, 8'hE1);
    run_op("not7", 1'b1, 4'h3, 4'h0, 3'b111, 8'hFC);
    run_op("neq_eq", 1'b1, 4'h5, 4'h5, 3'b011, 8'h00);
    run_op("neq_ne", 1'b0, 4'h5, 4'h6, 3'b011, 8'h01);
    run_op("not2", 1'b0, 4'h3, 4'h9, 3'b010, 8'hFC);
    run_op("and", 1'b0, 4'hC, 4'hA, 3'b100, 8'h08);
    run_op("or", 1'b1, 4'hC, 4'hA, 3'b101, 8'h0E);

    // Response backpressure on port 0 with req1 waiting
    ifa.rsp0_ready = 1'b0;
    ifa.req0_valid = 1'b1; ifa.req0_a = 4'h2; ifa.req0_b = 4'h3; ifa.req0_s = 3'b000;
    step();
    ifa.req0_valid = 1'b0;
    ifa.req1_valid = 1'b1; ifa.req1_a = 4'h1; ifa.req1_b = 4'h1; ifa.req1_s = 3'b000;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp0_valid", 16'(ifa.rsp0_valid), 16'h1);
      chk("bp_rsp0_o", 16'(ifa.rsp0_o), 16'h05);
      chk("bp_req1_ready", 16'(ifa.req1_ready), 16'h0);
      chk("bp_busy", 16'(la_busy), 16'h1);
      step();
    end
    ifa.rsp0_ready = 1'b1;
    step();
    chk("bp_rsp0_clear", 16'(ifa.rsp0_valid), 16'h0);
    chk("bp_req1_ready_idle", 16'(ifa.req1_ready), 16'h1);
    step();
    ifa.req1_valid = 1'b0;
    chk("bp_req1_gid", 16'(la_gid), 16'h1);
    chk("bp_req1_alu_a", 16'(la_a), 16'h1);
    step();
    step();
    chk("bp_rsp1_valid", 16'(ifa.rsp1_valid), 16'h1);
    chk("bp_rsp1_o", 16'(ifa.rsp1_o), 16'h02);
    step();

    // Reset one cycle after accept aborts the operation
    ifa.req0_valid = 1'b1; ifa.req0_a = 4'h4; ifa.req0_b = 4'h4; ifa.req0_s = 3'b000;
    step();
    ifa.req0_valid = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 16'(la_busy), 16'h0);
    chk("mid_rst_gid", 16'(la_gid), 16'h0);
    chk("mid_rst_alu_a", 16'(la_a), 16'h0);
    chk("mid_rst_alu_b", 16'(la_b), 16'h0);
    chk("mid_rst_rsp0", 16'(ifa.rsp0_valid), 16'h0);
    step();
    chk("mid_rst_rsp0_held", 16'(ifa.rsp0_valid), 16'h0);
    reset_n = 1'b1;
    step();
    step();
    chk("post_rst_no_rsp0", 16'(ifa.rsp0_valid), 16'h0);
    chk("post_rst_idle", 16'(la_busy), 16'h0);
    run_op("post_rst", 1'b1, 4'h6, 4'h3, 3'b000, 8'h09);

    // ALU_LAT = 3 instance
    ifb.req0_valid = 1'b1; ifb.req0_a = 4'hD; ifb.req0_b = 4'h3; ifb.req0_s = 3'b001;
    #1;
    chk("lat3_ready", 16'(ifb.req0_ready), 16'h1);
    step();
    ifb.req0_valid = 1'b0;
    chk("lat3_alu_a_T", 16'(lb_a), 16'hD);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("lat3_alu_a_hold", 16'(lb_a), 16'hD);
      chk("lat3_alu_s_hold", 16'(lb_s), 16'h1);
      chk("lat3_rsp_early", 16'(ifb.rsp0_valid), 16'h0);
    end
    step();
    chk("lat3_rsp_valid", 16'(ifb.rsp0_valid), 16'h1);
    chk("lat3_rsp_o", 16'(ifb.rsp0_o), 16'h27);
    chk("lat3_alu_b_hold", 16'(lb_b), 16'h3);
    step();
    chk("lat3_done", 16'(lb_busy), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the team's 4-bit registered ALU between two requesters. The ALU has opcode input s and an 8-bit result o sampled on the clock edge.
- Round-robin arbitration across the two request ports, valid/ready handshakes on both request and response sides.
- Drives the ALU operand and opcode inputs, waits out the ALU latency, then returns the captured result to the winning requester.
- Sits between client blocks and the shared ALU instance.

Parameters:
- AW, 4, operand width of a/b.
- SW, 3, opcode width.
- OW, 8, ALU result width.
- ALU_LAT, 1, clock edges from operands stable at the ALU to its registered result updating (≥1).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  operation request.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  AW  operands.
- req0_s / req1_s  in  SW  opcode: 000 add, 001 mul, 011 neq, 100 and, 101 or, 110 xor, other = not a.
- rsp0_valid / rsp1_valid  out  1  result available.
- rsp0_ready / rsp1_ready  in  1  result consumed.
- rsp0_o / rsp1_o  out  OW  result.
- alu_a, alu_b  out  AW  registered operands to the ALU.
- alu_s  out  SW  registered opcode to the ALU.
- alu_o  in  OW  ALU result.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  1  requester currently owning the ALU.

Behaviour:
- Reset values:
  - state = IDLE.
  - alu_a = 0, alu_b = 0, alu_s = 000.
  - rsp*_valid = 0, rsp*_o = 0.
  - busy = 0, grant_id = 0.
  - last_grant = 1, so req0 wins the first tie.
- Reset is asynchronous. Asserting reset_n low mid-operation aborts the operation: the pending result is discarded and no rsp is ever issued for it.
- IDLE:
  - Winner is selected combinationally. If only one req is valid, it wins. If both are valid, the winner is the requester that is not last_grant.
  - req_ready of the winner is high only in IDLE; the other req_ready is 0. Every req_ready is 0 in all other states.
  - On the handshake (valid & ready): register the winner's a/b/s into alu_a/alu_b/alu_s, set grant_id, load the wait counter with ALU_LAT, and go to EXEC.
- EXEC:
  - alu_a/alu_b/alu_s are held stable.
  - The counter decrements each edge. EXEC lasts ALU_LAT+1 edges.
  - On the final EXEC edge, capture alu_o into rsp<grant_id>_o, set rsp<grant_id>_valid, and go to RESP.
  - With ALU_LAT = 1: accept at edge T, capture at edge T+2, rsp_valid is high from T+2.
- RESP:
  - rsp_valid and rsp_o are held stable until rsp_ready is high at an edge.
  - On that edge: clear rsp_valid, set last_grant = grant_id, go to IDLE.
  - rsp_ready on the non-granted port is ignored.
- Throughput: one operation per ALU_LAT+3 cycles when rsp_ready is held high (IDLE, EXEC×(ALU_LAT+1), RESP).
- Requester protocol: once asserted, valid and operands are held until ready. Dropping valid before ready simply withdraws the request; the arbiter holds no request state.
- Results are passed through unmodified; the arbiter does no width or arithmetic manipulation. Expected ALU values:
  - add and mul are zero-extended to OW.
  - neq yields 8'h00 or 8'h01.
  - "not" inverts a after zero-extension to OW, e.g. a = 4'h3 gives 8'hFC.
- Opcodes 010 and 111 are forwarded as-is.
- A new request arriving during EXEC or RESP waits with ready = 0. Arbitration is re-evaluated fresh in IDLE.

Test Plan:
- Single add: req0 a=7, b=9, s=000 from reset → req0_ready at once, rsp0_valid 2 edges after accept, rsp0_o=8'h10, busy high across EXEC/RESP.
- Tie then fairness: req0 (a=3, b=4, s=000) and req1 (a=A, b=5, s=110) both valid from reset → req0 served first (rsp0_o=8'h07), then req1 (rsp1_o=8'h0F). With both held continuously valid, grants alternate 0,1,0,1.
- Multiply and not: req1 a=F, b=F, s=001 → rsp1_o=8'hE1. Then req1 a=3, s=111 → rsp1_o=8'hFC. Then a=5, b=5, s=011 → 8'h00.
- Response backpressure: rsp0_ready low for 5 cycles after rsp0_valid → rsp0_valid and rsp0_o stable throughout, req1_ready stays 0 with req1 valid. req1 accepted the cycle after rsp0_ready rises.
- Reset mid-EXEC: assert reset_n low one cycle after a req0 accept → all outputs return to reset values asynchronously and no rsp0_valid appears. After release, req1 is served normally.
- ALU_LAT=3 build: accept at edge T → alu operands stable T..T+4, rsp valid from edge T+4 with the correct result.
